// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, per-button counter debounce,
// debounced level plus single-cycle press/release strobes (maskable).
//
// Effective per-button states (derived from pressed_q and cnt_q, no separate state register):
//   state      | meaning
//   IDLE_UP    | released, raw agrees, cnt = 0
//   COUNT_DOWN | released, raw shows pressed, counting toward acceptance
//   HELD       | pressed, raw agrees, cnt = 0
//   COUNT_UP   | pressed, raw shows released, counting toward acceptance
module key_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] key_n,
  input  logic [N_BTN-1:0] mask,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] pressed_q, pressed_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] raw_p;

  always_comb begin
    s1_d      = key_n;
    s2_d      = s1_q;
    raw_p     = ~s2_q;
    pressed_d = pressed_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      // Any agreement with the accepted level clears the count, so bounces never accumulate.
      cnt_d[i] = '0;
      if (raw_p[i] != pressed_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          pressed_d[i] = raw_p[i];
          press_d[i]   = raw_p[i] & ~mask[i];
          release_d[i] = ~raw_p[i] & ~mask[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4: stimulus queues
// expected pulse events, a negedge monitor matches them against DUT strobes.
module tb_key_conditioner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] key_n;
  logic [2:0] mask;
  logic [2:0] pressed;
  logic [2:0] press_pulse;
  logic [2:0] release_pulse;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lvl;
  } exp_t;

  exp_t exp_q[$];

  key_conditioner #(
    .N_BTN(3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .key_n(key_n),
    .mask(mask),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Queue a pulse event expected 2+DEBOUNCE_CYCLES edges after this drive point.
  task automatic expect_pulse(input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    exp_t e;
    e.cyc   = cyc + 6;
    e.press = p;
    e.rel   = r;
    e.lvl   = l;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if ((press_pulse | release_pulse) != 3'b000) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got press=%b release=%b expected none (cycle %0d)",
                 press_pulse, release_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("press_pulse", int'(press_pulse), int'(e.press));
        check("release_pulse", int'(release_pulse), int'(e.rel));
        check("pressed_at_pulse", int'(pressed), int'(e.lvl));
      end
    end
  end

  initial begin
    Reset = 1'b1;
    key_n = 3'b111;
    mask  = 3'b000;
    cycles(3);
    check("reset_pressed", int'(pressed), 0);
    check("reset_pulses", int'({press_pulse, release_pulse}), 0);
    Reset = 1'b0;
    cycles(20);
    check("idle_pressed", int'(pressed), 0);

    // Single clean press on button 1, held.
    key_n[1] = 1'b0;
    expect_pulse(3'b010, 3'b000, 3'b010);
    cycles(15);
    check("btn1_held", int'(pressed), 3'b010);

    // Bouncing button 0: short lows never accepted, then a steady low.
    for (int b = 0; b < 3; b++) begin
      key_n[0] = 1'b0;
      cycles(3);
      key_n[0] = 1'b1;
      cycles(2);
    end
    check("bounce_no_accept", int'(pressed), 3'b010);
    key_n[0] = 1'b0;
    expect_pulse(3'b001, 3'b000, 3'b011);
    cycles(15);
    check("btn0_held", int'(pressed), 3'b011);

    // Masked press on button 2: level follows, no pulse; exact latency boundary.
    mask[2]  = 1'b1;
    key_n[2] = 1'b0;
    cycles(5);
    check("masked_before_accept", int'(pressed), 3'b011);
    cycles(1);
    check("masked_at_accept", int'(pressed), 3'b111);
    cycles(8);
    mask[2] = 1'b0;
    cycles(3);
    key_n[2] = 1'b1;
    expect_pulse(3'b000, 3'b100, 3'b011);
    cycles(15);
    check("btn2_released", int'(pressed), 3'b011);

    // Release everything, then press all three together.
    key_n = 3'b111;
    expect_pulse(3'b000, 3'b011, 3'b000);
    cycles(15);
    key_n = 3'b000;
    expect_pulse(3'b111, 3'b000, 3'b111);
    cycles(10);
    check("all_held", int'(pressed), 3'b111);

    // Reset mid-hold, then re-acceptance after release of Reset.
    Reset = 1'b1;
    cycles(1);
    check("midreset_pressed", int'(pressed), 0);
    check("midreset_pulses", int'({press_pulse, release_pulse}), 0);
    cycles(2);
    Reset = 1'b0;
    expect_pulse(3'b111, 3'b000, 3'b111);
    cycles(20);
    check("post_reset_held", int'(pressed), 3'b111);

    check("scoreboard_drained", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_pulse: got none expected press=%b release=%b at cycle %0d",
               e.press, e.rel, e.cyc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw active-low DE2 push-buttons before the game logic sees them.
- Per button: 2-flop synchronizer, counter debounce, registered pressed level, single-cycle press/release pulses.
- Sits directly upstream of the game control, shot-keeping and duck-hit logic in toplevel.
- Replaces the bare one-flop inversion, so one physical press yields exactly one start/shot/hit event.

Parameters:
- N_BTN, 3: number of buttons conditioned; bit i of every vector belongs to button i.
- DEBOUNCE_CYCLES, 500000: consecutive Clk cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is 2..2^CNT_W-1.
- CNT_W, 20: width of each debounce counter.

Ports:
- Clk  input  1  system clock (CLOCK_50).
- Reset  input  1  synchronous, active-high reset.
- key_n  input  N_BTN  raw asynchronous buttons, active low (0 = pressed).
- mask  input  N_BTN  1 = suppress press_pulse/release_pulse for that button; level tracking continues.
- pressed  output  N_BTN  debounced level, active high (1 = held).
- press_pulse  output  N_BTN  one-cycle strobe on each accepted 0->1 of pressed.
- release_pulse  output  N_BTN  one-cycle strobe on each accepted 1->0 of pressed.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; no other clock or reset domain.
- Reset values:
  - sync flops = all 1s (released).
  - pressed = 0, press_pulse = 0, release_pulse = 0.
  - all counters = 0.
- Reset mid-debounce discards the partial count. A button held through reset is re-accepted 2+DEBOUNCE_CYCLES cycles after Reset deasserts, and press_pulse fires then.
- Synchronizer: s1 <= key_n; s2 <= s1; raw_p = ~s2.
- Per-button counter, all buttons independent and processed in parallel every cycle:
  - raw_p == pressed: cnt <= 0.
  - raw_p != pressed and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - raw_p != pressed and cnt == DEBOUNCE_CYCLES-1: pressed <= raw_p, cnt <= 0.
- Effective states per button: IDLE_UP, COUNT_DOWN, HELD, COUNT_UP. A mismatch that disappears before acceptance returns the button to its stable state with cnt cleared. Bounces never accumulate.
- Pulses are registered and assert on the same edge pressed updates:
  - press_pulse[i] <= accept & raw_p & ~mask[i].
  - release_pulse[i] <= accept & ~raw_p & ~mask[i].
  - Otherwise both are 0, so each pulse is high for exactly 1 cycle.
- mask is sampled on the accept edge only. Toggling mask never creates or delays a pulse, and a masked transition is lost, not deferred.
- Latency: a raw edge held steady changes pressed and fires the pulse exactly 2+DEBOUNCE_CYCLES Clk edges after it is first sampled.
- Counter never wraps: it saturates at the accept point and clears.
- press_pulse and release_pulse for the same button are never high together. Different buttons may pulse in the same cycle.
- Holding a button indefinitely gives one press_pulse and no repeats.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=3):
- Reset held 3 cycles with key_n=3'b111, then released -> pressed=0, pulses=0, and all stay 0 for 20 cycles.
- key_n[1] driven 0 and held -> pressed[1] rises and press_pulse[1]=1 for exactly 1 cycle, 6 edges after first sample. Other bits stay 0 and no further pulses occur.
- key_n[0] toggled 0/1 with low periods of 3 cycles (< DEBOUNCE_CYCLES after sync), then held 0 -> no pulse during bouncing, and a single press_pulse[0] 6 edges after the final steady low.
- Button 2 pressed with mask[2]=1, then released with mask[2]=0 -> pressed[2] follows both transitions, press_pulse[2] never fires, release_pulse[2] fires once.
- key_n=3'b000 applied simultaneously -> press_pulse=3'b111 in one cycle. Then Reset pulsed mid-hold -> outputs 0, and press_pulse=3'b111 again 6 edges after Reset deasserts.
